crc_scan_arbiter: RTL and testbench

//  Shares one CRC engine and one synchronous-read memory between NREQ requesters.

---
 rtl/crc_scan_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_crc_scan_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_scan_arbiter.sv
// Round-robin arbiter that streams a requested memory range through a shared CRC engine
// and returns the final CRC tagged with the requester id. Optional feature macro: CRC_CHECK_EN.
module crc_scan_arbiter #(
    parameter  int NREQ   = 2,
    parameter  int ADDR_W = 10,
    parameter  int DATA_W = 8,
    parameter  int CRC_W  = 16,
    localparam int ID_W   = $clog2(NREQ),
    localparam int LEN_W  = ADDR_W + 1
) (
    input  logic                     clk50m,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_base,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     crc_init,
    output logic                     crc_en,
    output logic [DATA_W-1:0]        crc_data,
    input  logic [CRC_W-1:0]         crc_value,
`ifdef CRC_CHECK_EN
    input  logic [NREQ*CRC_W-1:0]    req_exp,
    output logic                     crc_err,
`endif
    output logic [CRC_W-1:0]         result,
    output logic [ID_W-1:0]          result_id,
    output logic                     result_valid
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ID_W-1:0]     sel_r;
    logic [ID_W-1:0]     rr_r;
    logic [ID_W-1:0]     pick_s;
    logic [ID_W-1:0]     sel_n_s;
    logic [ADDR_W-1:0]   base_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    cnt_r;
    logic                take_s;

    logic [NREQ-1:0]     gnt_r;
    logic [NREQ-1:0]     done_r;
    logic                busy_r;
    logic                mem_rd_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                crc_init_r;
    logic                crc_en_r;
    logic [CRC_W-1:0]    result_r;
    logic [ID_W-1:0]     result_id_r;
    logic                result_valid_r;

    // First requester at or above the round-robin pointer, wrapping around.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [ID_W-1:0] p);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && r[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Next-state selection and arbitration result.
    always_comb begin
        state_s = state_r;
        pick_s  = rr_pick(req, rr_r);
        take_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_s = ST_INIT;
                    take_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (len_r == '0) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_READ: begin
                if (cnt_r == LEN_W'(1'b1)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: state_s = ST_WAIT;
            ST_WAIT:  state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
        if (take_s) begin
            sel_n_s = pick_s;
        end else begin
            sel_n_s = sel_r;
        end
    end

`ifdef CRC_CHECK_EN
    logic [CRC_W-1:0] exp_r;
    logic             crc_err_r;

    // Expected CRC latched with the grant; compare registered when the result is reported.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            exp_r     <= '0;
            crc_err_r <= 1'b0;
        end else begin
            if (take_s) begin
                exp_r <= req_exp[int'(pick_s)*CRC_W +: CRC_W];
            end
            if (state_s == ST_DONE) begin
                crc_err_r <= (crc_value != exp_r);
            end
        end
    end

    assign crc_err = crc_err_r;
`endif

    // Control state: FSM register, latched job, read counter and round-robin pointer.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
            rr_r    <= '0;
            base_r  <= '0;
            len_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            if (take_s) begin
                sel_r  <= pick_s;
                base_r <= req_base[int'(pick_s)*ADDR_W +: ADDR_W];
                len_r  <= req_len[int'(pick_s)*LEN_W +: LEN_W];
            end
            if (state_r == ST_INIT) begin
                cnt_r <= len_r;
            end else if (state_r == ST_READ) begin
                cnt_r <= cnt_r - LEN_W'(1'b1);
            end
            if (state_r == ST_DONE) begin
                if (sel_r == ID_W'(NREQ - 1)) begin
                    rr_r <= '0;
                end else begin
                    rr_r <= sel_r + ID_W'(1'b1);
                end
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r          <= '0;
            done_r         <= '0;
            busy_r         <= 1'b0;
            mem_rd_r       <= 1'b0;
            mem_addr_r     <= '0;
            crc_init_r     <= 1'b0;
            crc_en_r       <= 1'b0;
            result_r       <= '0;
            result_id_r    <= '0;
            result_valid_r <= 1'b0;
        end else begin
            gnt_r          <= (state_s != ST_IDLE) ? onehot(sel_n_s) : '0;
            done_r         <= (state_s == ST_DONE) ? onehot(sel_r) : '0;
            busy_r         <= (state_s != ST_IDLE);
            mem_rd_r       <= (state_s == ST_READ);
            crc_init_r     <= (state_s == ST_INIT);
            crc_en_r       <= mem_rd_r;
            result_valid_r <= (state_s == ST_DONE);
            if (state_s == ST_READ) begin
                if (state_r == ST_INIT) begin
                    mem_addr_r <= base_r;
                end else begin
                    mem_addr_r <= mem_addr_r + ADDR_W'(1'b1);
                end
            end
            if (state_s == ST_DONE) begin
                result_r    <= crc_value;
                result_id_r <= sel_r;
            end
        end
    end

    assign gnt          = gnt_r;
    assign done         = done_r;
    assign busy         = busy_r;
    assign mem_rd       = mem_rd_r;
    assign mem_addr     = mem_addr_r;
    assign crc_init     = crc_init_r;
    assign crc_en       = crc_en_r;
    assign crc_data     = mem_rdata;
    assign result       = result_r;
    assign result_id    = result_id_r;
    assign result_valid = result_valid_r;

endmodule

// File: tb/tb_crc_scan_arbiter.sv
// Scoreboard bench for crc_scan_arbiter: a memory and CRC-16 engine model surround the DUT,
// expected results are queued at request time and popped by a monitor on result_valid.
module tb_crc_scan_arbiter;
    localparam int NREQ   = 2;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int CRC_W  = 16;
    localparam int ID_W   = 1;
    localparam int LEN_W  = 11;
    localparam logic [15:0] SEED = 16'hFFFF;

    logic                   clk50m = 1'b0;
    logic                   rst_n  = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*ADDR_W-1:0] req_base = '0;
    logic [NREQ*LEN_W-1:0]  req_len = '0;
    logic [NREQ-1:0]        gnt, done;
    logic                   busy, mem_rd, crc_init, crc_en, result_valid;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_rdata = '0;
    logic [DATA_W-1:0]      crc_data;
    logic [CRC_W-1:0]       crc_value = '0;
    logic [CRC_W-1:0]       result;
    logic [ID_W-1:0]        result_id;
`ifdef CRC_CHECK_EN
    logic [NREQ*CRC_W-1:0]  req_exp = '0;
    logic                   crc_err;
`endif

    always #10 clk50m = ~clk50m;

    crc_scan_arbiter dut (
        .clk50m(clk50m), .rst_n(rst_n), .req(req), .req_base(req_base), .req_len(req_len),
        .gnt(gnt), .done(done), .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .crc_init(crc_init), .crc_en(crc_en), .crc_data(crc_data),
        .crc_value(crc_value),
`ifdef CRC_CHECK_EN
        .req_exp(req_exp), .crc_err(crc_err),
`endif
        .result(result), .result_id(result_id), .result_valid(result_valid)
    );

    logic [7:0] mem [0:1023];

    // Bit-serial CRC-16/CCITT engine step (MSB first, poly 0x1021).
    function automatic logic [15:0] eng_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        logic        fb;
        x = c;
        for (int i = 7; i >= 0; i--) begin
            fb = x[15] ^ d[i];
            x  = {x[14:0], 1'b0};
            if (fb) x = x ^ 16'h1021;
        end
        return x;
    endfunction

    // Reference: CRC of the words base, base+1, ... (mod 1024), byte-wise formulation.
    function automatic logic [15:0] model_crc(input int base, input int len);
        logic [15:0] c;
        c = SEED;
        for (int j = 0; j < len; j++) begin
            c = c ^ {mem[(base + j) % 1024], 8'h00};
            for (int b = 0; b < 8; b++) begin
                if (c[15]) c = {c[14:0], 1'b0} ^ 16'h1021;
                else       c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    always @(posedge clk50m) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk50m) begin
        if (crc_init)    crc_value <= SEED;
        else if (crc_en) crc_value <= eng_step(crc_value, crc_data);
    end

    typedef struct {
        int          id;
        logic [15:0] crc;
        int          len;
        logic        err;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   init_cyc = 0;
    int   rd_cnt = 0;
    int   en_cnt = 0;
    int   rr_m = 0;
    int   bases [NREQ];
    int   lens  [NREQ];
    logic bad   [NREQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is presented.
    initial begin
        exp_t e;
        logic multi;
        forever begin
            @(negedge clk50m);
            cyc++;
            if (!rst_n) begin
                rd_cnt = 0;
                en_cnt = 0;
            end else begin
                if (crc_init) begin
                    init_cyc = cyc;
                    rd_cnt   = 0;
                    en_cnt   = 0;
                end
                if (mem_rd) rd_cnt++;
                if (crc_en) en_cnt++;
                multi = ($countones(gnt) > 1);
                check("gnt_onehot0", 32'(multi), 32'd0);
                if (result_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("result_id", 32'(result_id), e.id);
                        check("result_crc", 32'(result), 32'(e.crc));
                        check("done_onehot", 32'(done), 32'(1 << e.id));
                        check("gnt_in_done", 32'(gnt), 32'(1 << e.id));
                        check("mem_rd_count", rd_cnt, e.len);
                        check("crc_en_count", en_cnt, e.len);
                        check("latency", cyc - init_cyc, (e.len == 0) ? 2 : e.len + 3);
`ifdef CRC_CHECK_EN
                        check("crc_err", 32'(crc_err), 32'(e.err));
`endif
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_crc_init"}, 32'(crc_init), 32'd0);
        check({tag, "_crc_en"}, 32'(crc_en), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_result_id"}, 32'(result_id), 32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    endtask

    // Drive a set of simultaneous requests and queue their results in round-robin order.
    task automatic start_round(input logic [NREQ-1:0] subset);
        exp_t e;
        int   i;
        int   last;
        last = rr_m;
        for (int k = 0; k < NREQ; k++) begin
            i = (rr_m + k) % NREQ;
            if (subset[i]) begin
                e.id  = i;
                e.len = lens[i];
                e.crc = model_crc(bases[i], lens[i]);
                e.err = bad[i];
                sb.push_back(e);
                last = i;
            end
        end
        rr_m = (last + 1) % NREQ;
        for (int k = 0; k < NREQ; k++) begin
            req_base[k*ADDR_W +: ADDR_W] = ADDR_W'(bases[k]);
            req_len[k*LEN_W +: LEN_W]    = LEN_W'(lens[k]);
`ifdef CRC_CHECK_EN
            req_exp[k*CRC_W +: CRC_W] = model_crc(bases[k], lens[k]) ^ (bad[k] ? 16'h0001 : 16'h0000);
`endif
        end
        req = subset;
    endtask

    // Hold each request until its done pulse, then wait for the block to go idle.
    task automatic wait_round();
        int c;
        c = 0;
        while ((req != '0 || sb.size() != 0) && c < 3000) begin
            @(negedge clk50m);
            req = req & ~done;
            c++;
        end
        if (req != '0 || sb.size() != 0) begin
            check("round_timeout", 32'd1, 32'd0);
            sb.delete();
            req = '0;
            rst_n = 1'b0;
            rr_m = 0;
            @(negedge clk50m);
            rst_n = 1'b1;
        end
        c = 0;
        while (busy && c < 20) begin
            @(negedge clk50m);
            c++;
        end
        check("idle_after_round", 32'(busy), 32'd0);
    endtask

    initial begin
        int c;
        for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
        for (int k = 0; k < NREQ; k++) begin
            bases[k] = 0;
            lens[k]  = 0;
            bad[k]   = 1'b0;
        end
        repeat (3) @(negedge clk50m);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk50m);

        // Single request, base 0, length 4: cycle-exact grant and address checks.
        bases[0] = 0;
        lens[0]  = 4;
        start_round(2'b01);
        @(posedge clk50m); #1;
        check("t1_gnt_c1", 32'(gnt), 32'd1);
        check("t1_init_c1", 32'(crc_init), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk50m); #1;
            check("t1_mem_rd", 32'(mem_rd), 32'd1);
            check("t1_mem_addr", 32'(mem_addr), 32'(k));
        end
        wait_round();

        // Address wrap, empty range, full range.
        bases[0] = 1022; lens[0] = 4;    bad[0] = 1'b1; start_round(2'b01); wait_round();
        bases[0] = 5;    lens[0] = 0;    bad[0] = 1'b0; start_round(2'b01); wait_round();
        bases[0] = 300;  lens[0] = 1024; bad[0] = 1'b1; start_round(2'b01); wait_round();

        // Both requesters held together, twice.
        for (int r = 0; r < 2; r++) begin
            bases[0] = 16'($urandom_range(0, 1023)); lens[0] = 2; bad[0] = 1'(r);
            bases[1] = 16'($urandom_range(0, 1023)); lens[1] = 2; bad[1] = 1'(1 - r);
            start_round(2'b11);
            wait_round();
        end

        // Reset in the middle of a scan, then restart with the request still held.
        bases[0] = 1020; lens[0] = 8; bad[0] = 1'b0;
        start_round(2'b01);
        c = 0;
        while (!mem_rd && c < 20) begin
            @(negedge clk50m);
            c++;
        end
        check("t5_reached_read", 32'(mem_rd), 32'd1);
        repeat (2) @(negedge clk50m);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        rr_m = 0;
        @(negedge clk50m);
        rst_n = 1'b1;
        start_round(2'b01);
        c = 0;
        while (!mem_rd && c < 20) begin
            @(negedge clk50m);
            c++;
        end
        check("t5_restart_rd", 32'(mem_rd), 32'd1);
        check("t5_restart_addr", 32'(mem_addr), 32'd1020);
        wait_round();

        // Random rounds.
        for (int r = 0; r < 30; r++) begin
            logic [NREQ-1:0] subset;
            subset = NREQ'($urandom_range(1, 3));
            for (int k = 0; k < NREQ; k++) begin
                bases[k] = $urandom_range(0, 1023);
                lens[k]  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
                bad[k]   = 1'($urandom_range(0, 1));
            end
            start_round(subset);
            wait_round();
        end

        repeat (3) @(negedge clk50m);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
